// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the 2-input gate test sequencer.
// Truth tables are indexed by {a,b}, with a as the MSB.
package gate_seq_pkg;

    localparam int unsigned VEC_W   = 2;
    localparam int unsigned NUM_VEC = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [NUM_VEC-1:0] TT_OR2   = 4'b1110;
    localparam logic [NUM_VEC-1:0] TT_AND2  = 4'b1000;
    localparam logic [NUM_VEC-1:0] TT_XOR2  = 4'b0110;
    localparam logic [NUM_VEC-1:0] TT_NOR2  = 4'b0001;
    localparam logic [NUM_VEC-1:0] TT_NAND2 = 4'b0111;

    // True when the observed output disagrees with the truth table entry.
    function automatic logic vec_fail(input logic [NUM_VEC-1:0] tt,
                                      input logic [VEC_W-1:0]   idx,
                                      input logic               y);
        return y != tt[idx];
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Hold-window counter: counts 0..HOLD_CYCLES-1 while enabled and flags the
// last cycle of each window; restarts at zero on load or reset.
module hold_timer #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] hold_cnt;

    assign expire_c = en && (hold_cnt == LAST);

    // Wraps back to zero at the end of each window, never past LAST.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (load) begin
            hold_cnt <= '0;
        end else if (en) begin
            hold_cnt <= expire_c ? '0 : hold_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/gate_test_sequencer.sv
// Walks a 2-input gate through all four input vectors, samples its output at
// the end of each hold window and records mismatches against EXPECTED.
module gate_test_sequencer
    import gate_seq_pkg::*;
#(
    parameter int unsigned        HOLD_CYCLES = 4,
    parameter logic [NUM_VEC-1:0] EXPECTED    = TT_OR2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               gate_y,
    output logic               gate_a,
    output logic               gate_b,
    output logic [VEC_W-1:0]   vec_idx,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NUM_VEC-1:0] fail_mask
);

    state_t             state;
    state_t             state_nxt;
    logic [VEC_W-1:0]   vec_r;
    logic [NUM_VEC-1:0] fail_r;
    logic               expire;
    logic               last_vec;

    assign last_vec = (vec_r == VEC_W'(NUM_VEC - 1));

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state != DRIVE),
        .en       (state == DRIVE),
        .expire_c (expire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is ignored while a run is in progress.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DRIVE;
            DRIVE:   if (expire && last_vec) state_nxt = DONE;
            DONE:    if (start) state_nxt = DRIVE;
            default: state_nxt = IDLE;
        endcase
    end

    // Vector index and mismatch capture; vec_r wraps to 0 after the last vector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_r  <= '0;
            fail_r <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        vec_r  <= '0;
                        fail_r <= '0;
                    end
                end
                DRIVE: begin
                    if (expire) begin
                        fail_r[vec_r] <= vec_fail(EXPECTED, vec_r, gate_y);
                        vec_r         <= vec_r + VEC_W'(1);
                    end
                end
                default: begin
                    vec_r  <= '0;
                    fail_r <= '0;
                end
            endcase
        end
    end

    // Status outputs decoded from the state and mismatch registers.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        pass = 1'b0;
        case (state)
            DRIVE:   busy = 1'b1;
            DONE: begin
                done = 1'b1;
                pass = (fail_r == '0);
            end
            default: ;
        endcase
    end

    assign gate_a    = vec_r[1];
    assign gate_b    = vec_r[0];
    assign vec_idx   = vec_r;
    assign fail_mask = fail_r;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer: one instance with 4-cycle holds, one with
// 1-cycle holds, each exercising a behavioural gate model.
module tb_gate_test_sequencer;
    import gate_seq_pkg::*;

    logic       clk;
    logic       rst_n_v   [2];
    logic       start_v   [2];
    logic       gate_y_v  [2];
    logic       ga_v      [2];
    logic       gb_v      [2];
    logic [1:0] vidx_v    [2];
    logic       busy_v    [2];
    logic       done_v    [2];
    logic       pass_v    [2];
    logic [3:0] fm_v      [2];
    logic [3:0] gate_tt   [2];

    int tests;
    int fails;

    gate_test_sequencer #(.HOLD_CYCLES(4), .EXPECTED(TT_OR2)) dut4 (
        .clk(clk), .rst_n(rst_n_v[0]), .start(start_v[0]), .gate_y(gate_y_v[0]),
        .gate_a(ga_v[0]), .gate_b(gb_v[0]), .vec_idx(vidx_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .pass(pass_v[0]), .fail_mask(fm_v[0])
    );

    gate_test_sequencer #(.HOLD_CYCLES(1), .EXPECTED(TT_OR2)) dut1 (
        .clk(clk), .rst_n(rst_n_v[1]), .start(start_v[1]), .gate_y(gate_y_v[1]),
        .gate_a(ga_v[1]), .gate_b(gb_v[1]), .vec_idx(vidx_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .pass(pass_v[1]), .fail_mask(fm_v[1])
    );

    // Gate under test: an arbitrary truth table looked up by {a,b}.
    assign gate_y_v[0] = gate_tt[0][{ga_v[0], gb_v[0]}];
    assign gate_y_v[1] = gate_tt[1][{ga_v[1], gb_v[1]}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] tt;
        logic [3:0] exp_mask;
        logic       exp_pass;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int hold_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {busy, done, pass, vec_idx, gate_a, gate_b, fail_mask}
    function automatic logic [15:0] snap(input int d);
        return {7'd0, busy_v[d], done_v[d], pass_v[d], vidx_v[d], ga_v[d], gb_v[d], fm_v[d]};
    endfunction

    function automatic logic [15:0] exp_snap(input logic busy, input logic done, input logic pass,
                                             input logic [1:0] v, input logic [3:0] fm);
        return {7'd0, busy, done, pass, v, v[1], v[0], fm};
    endfunction

    // One full run from IDLE or DONE; optional ignored start pulse at cycle glitch.
    task automatic run(input int d, input string name, input logic [3:0] tt,
                       input logic [3:0] exp_mask, input int glitch);
        int h;
        int busy_cycles;
        logic [1:0] v;
        h = hold_of(d);
        busy_cycles = 0;
        gate_tt[d] = tt;
        start_v[d] = 1'b1;
        tick();
        start_v[d] = 1'b0;
        check($sformatf("%s start", name), {12'd0, busy_v[d], done_v[d], fm_v[d] == 4'd0, pass_v[d]},
              {12'd0, 1'b1, 1'b0, 1'b1, 1'b0});
        for (int c = 0; c < 4 * h; c++) begin
            v = 2'(c / h);
            if (busy_v[d]) busy_cycles++;
            check($sformatf("%s vec c%0d", name, c),
                  {10'd0, busy_v[d], done_v[d], vidx_v[d], ga_v[d], gb_v[d]},
                  {10'd0, 1'b1, 1'b0, v, v[1], v[0]});
            start_v[d] = (c == glitch);
            tick();
        end
        start_v[d] = 1'b0;
        check($sformatf("%s busy_len", name), 16'(busy_cycles), 16'(4 * h));
        check($sformatf("%s end", name), snap(d), exp_snap(1'b0, 1'b1, exp_mask == 4'd0, 2'd0, exp_mask));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int d = 0; d < 2; d++) begin
            rst_n_v[d] = 1'b0;
            start_v[d] = 1'b0;
            gate_tt[d] = TT_OR2;
        end

        tbl[0] = '{tt: TT_OR2,   exp_mask: 4'b0000, exp_pass: 1'b1};
        tbl[1] = '{tt: 4'b0000,  exp_mask: 4'b1110, exp_pass: 1'b0};
        tbl[2] = '{tt: TT_AND2,  exp_mask: 4'b0110, exp_pass: 1'b0};
        tbl[3] = '{tt: TT_XOR2,  exp_mask: 4'b1000, exp_pass: 1'b0};
        tbl[4] = '{tt: TT_NAND2, exp_mask: 4'b1001, exp_pass: 1'b0};
        tbl[5] = '{tt: TT_NOR2,  exp_mask: 4'b1111, exp_pass: 1'b0};
        tbl[6] = '{tt: 4'b1111,  exp_mask: 4'b0001, exp_pass: 1'b0};

        tick();
        tick();
        for (int d = 0; d < 2; d++)
            check($sformatf("reset d%0d", d), snap(d), 16'd0);
        rst_n_v[0] = 1'b1;
        rst_n_v[1] = 1'b1;
        tick();
        check("idle no start", snap(0), 16'd0);

        // Truth-table vectors on both hold lengths.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 7; i++) begin
                run(d, $sformatf("tbl d%0d i%0d", d, i), tbl[i].tt, tbl[i].exp_mask, -1);
                check($sformatf("tbl d%0d i%0d pass", d, i), 16'(pass_v[d]), 16'(tbl[i].exp_pass));
            end
        end

        // Start pulse at cycle 6 of a run is ignored; DONE holds until next start.
        run(0, "glitch6", TT_OR2, 4'b0000, 6);
        tick();
        tick();
        check("done held", snap(0), exp_snap(1'b0, 1'b1, 1'b1, 2'd0, 4'd0));
        run(0, "restart", TT_AND2, 4'b0110, -1);
        run(0, "restart2", TT_OR2, 4'b0000, -1);

        // Reset during vector 2 with start held high.
        gate_tt[0] = TT_AND2;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (9) tick();
        check("mid vec2", {14'd0, vidx_v[0]}, 16'd2);
        rst_n_v[0] = 1'b0;
        start_v[0] = 1'b1;
        tick();
        check("mid reset", snap(0), 16'd0);
        rst_n_v[0] = 1'b1;
        start_v[0] = 1'b0;
        tick();
        check("post reset idle", snap(0), 16'd0);
        run(0, "after reset", TT_OR2, 4'b0000, -1);

        // start held continuously: DONE lasts exactly one cycle.
        gate_tt[1] = TT_XOR2;
        start_v[1] = 1'b1;
        repeat (4) tick();
        check("cont last vec", snap(1), exp_snap(1'b1, 1'b0, 1'b0, 2'd3, 4'b0000));
        tick();
        check("cont done", snap(1), exp_snap(1'b0, 1'b1, 1'b0, 2'd0, 4'b1000));
        tick();
        check("cont restart", snap(1), exp_snap(1'b1, 1'b0, 1'b0, 2'd0, 4'b0000));
        start_v[1] = 1'b0;
        repeat (4) tick();
        check("cont second done", snap(1), exp_snap(1'b0, 1'b1, 1'b0, 2'd0, 4'b1000));

        // Random gates against the model: mismatch mask is tt XOR expected table.
        for (int n = 0; n < 24; n++) begin
            int d;
            int g;
            logic [3:0] tt;
            d  = n % 2;
            tt = 4'($urandom_range(0, 15));
            g  = $urandom_range(0, 4 * hold_of(d)) - 1;
            run(d, $sformatf("rand n%0d tt%0h", n, tt), tt, tt ^ TT_OR2, g);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
